// File: rtl/ascon_state_loader_pkg.sv
// ----------------------------------------------------------------------------
// ascon_state_loader_pkg
// Shared types and constants for the Ascon initialization front/back end.
//   state_t       : five 64-bit lanes, element [0] is x0 ... element [4] is x4
//   ASCON128_IV   : Ascon-128 initialization vector placed in x0
//   *_WORD_BASE   : first word index of the key and nonce in the write map
//   MASK_*        : load-mask patterns (bit w set once word w was written)
//   fsm_state_e   : loader control states
// ----------------------------------------------------------------------------
package ascon_state_loader_pkg;

    typedef logic [4:0][63:0] state_t;

    localparam logic [63:0] ASCON128_IV = 64'h80400c0600000000;

    localparam logic [2:0] KEY_WORD_BASE   = 3'd0;
    localparam logic [2:0] NONCE_WORD_BASE = 3'd4;

    localparam logic [7:0] MASK_ALL   = 8'hFF;
    localparam logic [7:0] MASK_NONCE = 8'hF0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        FINAL,
        OUT
    } fsm_state_e;

endpackage

// File: rtl/ascon_state_loader.sv
// ----------------------------------------------------------------------------
// ascon_state_loader
// Loads a 128-bit key and nonce through 32-bit word writes, presents
// IV||K||N to the Ascon init stage, launches it, captures the permuted state,
// applies the closing key XOR to x3/x4 and hands the result downstream.
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   we_i, addr_i, wdata_i : word write (0-3 key, 4-7 nonce, big-endian)
//   go_i                  : request an initialization run
//   clr_err_i             : clear sticky errors (a coincident set wins)
//   busy_o                : high whenever the FSM is not IDLE
//   err_o                 : sticky [0] incomplete load on go, [1] timeout
//   init_start_o          : one-cycle start pulse to the init stage
//   init_state_o          : initial state IV||K||N
//   init_state_i          : permuted state, valid when init_update_i
//   init_finished_i       : init stage completion pulse
//   out_state_o           : initialized state
//   out_valid_o/out_ready_i : downstream handshake
// ----------------------------------------------------------------------------
module ascon_state_loader
    import ascon_state_loader_pkg::*;
#(
    parameter logic [63:0] IV             = ASCON128_IV,
    parameter int          TIMEOUT_CYCLES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic        go_i,
    input  logic        clr_err_i,
    output logic        busy_o,
    output logic [1:0]  err_o,
    output logic        init_start_o,
    output state_t      init_state_o,
    input  state_t      init_state_i,
    input  logic        init_update_i,
    input  logic        init_finished_i,
    output state_t      out_state_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fsm_state_e        state_q, state_d;
    // Word 0 of each 128-bit value is its most significant word, so word w
    // lives in packed slot 3-w (i.e. ~w for a 2-bit index).
    logic [3:0][31:0]  key_q, nonce_q;
    logic [7:0]        mask_q;
    logic [1:0]        err_q, err_set;
    logic [CNT_W-1:0]  cnt_q;
    state_t            state_reg_q;
    logic [1:0]        key_slot, nonce_slot;

    assign key_slot   = 2'(addr_i - KEY_WORD_BASE);
    assign nonce_slot = 2'(addr_i - NONCE_WORD_BASE);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        err_set = 2'b00;
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    if (mask_q == MASK_ALL) state_d = START;
                    else                    err_set[0] = 1'b1;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                // finished has priority over a timeout on the same cycle
                if (init_finished_i) begin
                    state_d = FINAL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    err_set[1] = 1'b1;
                end
            end
            FINAL: state_d = OUT;
            OUT:   if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            // NOTE: key/nonce storage is reset so init_state_o never exposes
            // stale material from before a reset.
            key_q       <= '0;
            nonce_q     <= '0;
            mask_q      <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
            state_reg_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= (clr_err_i ? 2'b00 : err_q) | err_set;
            case (state_q)
                IDLE: begin
                    if (we_i) begin
                        if (addr_i >= NONCE_WORD_BASE) nonce_q[~nonce_slot] <= wdata_i;
                        else                           key_q[~key_slot]     <= wdata_i;
                        mask_q[addr_i] <= 1'b1;
                    end
                end
                START: cnt_q <= '0;
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (init_update_i) state_reg_q <= init_state_i;
                end
                FINAL: begin
                    state_reg_q[3] <= state_reg_q[3] ^ key_q[3:2];
                    state_reg_q[4] <= state_reg_q[4] ^ key_q[1:0];
                    // Nonce must be fully rewritten before the next run.
                    mask_q         <= mask_q & ~MASK_NONCE;
                end
                default: ;
            endcase
        end
    end

    assign init_state_o = {nonce_q[1:0], nonce_q[3:2], key_q[1:0], key_q[3:2], IV};
    assign out_state_o  = state_reg_q;
    assign out_valid_o  = (state_q == OUT);
    assign init_start_o = (state_q == START);
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;

endmodule

// File: tb/tb_ascon_state_loader.sv
// ----------------------------------------------------------------------------
// tb_ascon_state_loader
// Directed sequence with randomized key/nonce data against a behavioural
// model (word array + load flags + Ascon permutation). A small init-stage
// stand-in reacts to init_start_o in one of four modes.
// ----------------------------------------------------------------------------
module tb_ascon_state_loader;
    import ascon_state_loader_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, we_i, go_i, clr_err_i, out_ready_i;
    logic [2:0]  addr_i;
    logic [31:0] wdata_i;
    logic        busy_o, init_start_o, out_valid_o;
    logic [1:0]  err_o;
    logic        init_update_i, init_finished_i;
    state_t      init_state_o, init_state_i, out_state_o;

    int checks = 0;
    int errors = 0;

    // init stage stand-in: 0 real permutation, 1 all-zero, 2 update+finish coincide, 3 never finishes
    int     stub_mode = 0;
    int     stub_j    = 0;
    state_t stub_base;

    // reference model
    logic [31:0] m_word[8];
    bit          m_loaded[8];
    logic [1:0]  m_err;

    ascon_state_loader dut (
        .clk_i(clk_i), .rst_i(rst_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .go_i(go_i), .clr_err_i(clr_err_i), .busy_o(busy_o), .err_o(err_o),
        .init_start_o(init_start_o), .init_state_o(init_state_o),
        .init_state_i(init_state_i), .init_update_i(init_update_i),
        .init_finished_i(init_finished_i), .out_state_o(out_state_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // First n rounds of Ascon p12.
    function automatic state_t perm_rounds(input state_t s, input int n);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        state_t r;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        for (int i = 0; i < n; i++) begin
            x2 ^= {56'd0, 4'(15 - i), 4'(i)};
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1)  ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7)  ^ ror(x4, 41);
        end
        r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3; r[4] = x4;
        return r;
    endfunction

    function automatic state_t rand_state();
        state_t r;
        for (int k = 0; k < 5; k++) r[k] = {$urandom, $urandom};
        return r;
    endfunction

    function automatic logic [127:0] m_key();
        return {m_word[0], m_word[1], m_word[2], m_word[3]};
    endfunction

    function automatic logic [127:0] m_nonce();
        return {m_word[4], m_word[5], m_word[6], m_word[7]};
    endfunction

    function automatic state_t m_init();
        state_t r;
        logic [127:0] k, n;
        k = m_key(); n = m_nonce();
        r[0] = ASCON128_IV; r[1] = k[127:64]; r[2] = k[63:0]; r[3] = n[127:64]; r[4] = n[63:0];
        return r;
    endfunction

    function automatic state_t m_final(input state_t captured);
        state_t r;
        logic [127:0] k;
        k = m_key();
        r = captured;
        r[3] ^= k[127:64];
        r[4] ^= k[63:0];
        return r;
    endfunction

    function automatic bit m_all_loaded();
        for (int i = 0; i < 8; i++) if (!m_loaded[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) begin
            m_word[i]   = '0;
            m_loaded[i] = 1'b0;
        end
        m_err = 2'b00;
    endfunction

    function automatic void m_consume_nonce();
        for (int i = 4; i < 8; i++) m_loaded[i] = 1'b0;
    endfunction

    // init stage stand-in
    always @(posedge clk_i) begin : stub
        int j;
        if (rst_i) begin
            stub_j          <= 0;
            init_update_i   <= 1'b0;
            init_finished_i <= 1'b0;
            init_state_i    <= '0;
        end else begin
            if (init_start_o && stub_mode != 3) begin
                j = 1;
                stub_base = init_state_o;
            end else if (stub_j != 0 && stub_j < 12) begin
                j = stub_j + 1;
            end else begin
                j = 0;
            end
            stub_j          <= j;
            init_update_i   <= 1'b0;
            init_finished_i <= 1'b0;
            if (j >= 1 && j <= 11) begin
                init_update_i <= 1'b1;
                case (stub_mode)
                    0:       init_state_i <= perm_rounds(stub_base, j + 1);
                    1:       init_state_i <= '0;
                    default: init_state_i <= rand_state();
                endcase
            end else if (j == 12) begin
                init_finished_i <= 1'b1;
                if (stub_mode == 2) begin
                    init_update_i <= 1'b1;
                    init_state_i  <= perm_rounds(stub_base, 12);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input bit accepted);
        addr_i  = a;
        wdata_i = d;
        we_i    = 1'b1;
        tick();
        we_i    = 1'b0;
        if (accepted) begin
            m_word[a]   = d;
            m_loaded[a] = 1'b1;
        end
    endtask

    task automatic go_once();
        go_i = 1'b1;
        tick();
        go_i = 1'b0;
    endtask

    // lat holds the current cycle number relative to go (go = cycle 0)
    task automatic wait_valid(inout int lat);
        while (!out_valid_o && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        logic [31:0] tp[4];
        state_t      exp_s;
        int          lat, n, order[8], tmp, idx;
        bit          saw_valid, saw_start, saw_busy;

        tp[0] = 32'h00010203; tp[1] = 32'h04050607; tp[2] = 32'h08090a0b; tp[3] = 32'h0c0d0e0f;
        rst_i = 1'b1; we_i = 1'b0; go_i = 1'b0; clr_err_i = 1'b0; out_ready_i = 1'b0;
        addr_i = '0; wdata_i = '0;
        m_reset();
        tick(); tick();
        rst_i = 1'b0;

        // reset state
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 2'b00);
        chk("rst_start", init_start_o, 1'b0);
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_out_state", out_state_o, '0);
        chk("rst_init_state", init_state_o, m_init());

        // test-plan key/nonce, real permutation
        for (int i = 0; i < 4; i++) wr(3'(KEY_WORD_BASE + i), tp[i], 1'b1);
        for (int i = 0; i < 4; i++) wr(3'(NONCE_WORD_BASE + i), tp[i], 1'b1);
        chk("init_state_x0", init_state_o[0], 64'h80400c0600000000);
        chk("init_state_x1", init_state_o[1], 64'h0001020304050607);
        chk("init_state_x4", init_state_o[4], 64'h08090a0b0c0d0e0f);
        chk("init_state_all", init_state_o, m_init());
        stub_mode = 0;
        go_once();
        chk("start_hi", init_start_o, 1'b1);
        chk("busy_run", busy_o, 1'b1);
        tick();
        chk("start_lo", init_start_o, 1'b0);
        chk("init_state_stable", init_state_o, m_init());
        lat = 2;
        wait_valid(lat);
        chk("latency_real", lat, 15);
        exp_s = m_final(perm_rounds(m_init(), 12));
        chk("out_golden", out_state_o, exp_s);

        // backpressure: hold 10 cycles, writes during OUT dropped
        for (int k = 0; k < 10; k++) begin
            if (k % 3 == 0) wr(3'($urandom_range(7, 0)), $urandom, 1'b0);
            else            tick();
            chk("hold_valid", out_valid_o, 1'b1);
            chk("hold_state", out_state_o, exp_s);
        end
        chk("dropped_writes", init_state_o, m_init());
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        m_consume_nonce();
        chk("xfer_valid_lo", out_valid_o, 1'b0);
        chk("xfer_busy_lo", busy_o, 1'b0);

        // nonce reuse guard
        go_once();
        if (!m_all_loaded()) m_err[0] = 1'b1;
        chk("reuse_err", err_o, m_err);
        chk("reuse_no_start", init_start_o, 1'b0);
        chk("reuse_idle", busy_o, 1'b0);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        m_err = 2'b00;
        chk("clr_err", err_o, m_err);

        // 7 of 8 words loaded; go coincides with clear -> set wins
        for (int i = 0; i < 3; i++) wr(3'(NONCE_WORD_BASE + i), $urandom, 1'b1);
        go_i = 1'b1; clr_err_i = 1'b1;
        tick();
        go_i = 1'b0; clr_err_i = 1'b0;
        if (!m_all_loaded()) m_err[0] = 1'b1;
        chk("partial_err_set_wins", err_o, m_err);
        chk("partial_no_start", init_start_o, 1'b0);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        m_err = 2'b00;

        // all-zero init stage: output is just the key XOR
        wr(3'(NONCE_WORD_BASE + 3), $urandom, 1'b1);
        stub_mode = 1;
        go_once();
        lat = 1;
        wait_valid(lat);
        chk("zero_latency", lat, 15);
        chk("zero_out", out_state_o, m_final('0));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        m_consume_nonce();

        // random key/nonce in random order; update coincides with finished; go while busy ignored
        for (int i = 0; i < 8; i++) order[i] = i;
        for (int i = 7; i > 0; i--) begin
            idx = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[idx]; order[idx] = tmp;
        end
        for (int i = 0; i < 8; i++) wr(3'(order[i]), $urandom, 1'b1);
        chk("rand_init_state", init_state_o, m_init());
        stub_mode = 2;
        go_once();
        tick(); tick();
        go_once();
        lat = 4;
        wait_valid(lat);
        chk("coincide_latency", lat, 15);
        chk("busy_go_no_err", err_o, m_err);
        chk("coincide_out", out_state_o, m_final(perm_rounds(m_init(), 12)));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        m_consume_nonce();

        // init stage never finishes -> timeout after 32 WAIT cycles
        for (int i = 0; i < 4; i++) wr(3'(NONCE_WORD_BASE + i), $urandom, 1'b1);
        stub_mode = 3;
        go_once();
        n = 1;
        saw_valid = 1'b0;
        while (busy_o && n < 100) begin
            tick();
            n++;
            if (out_valid_o) saw_valid = 1'b1;
        end
        m_err[1] = 1'b1;
        chk("timeout_cycle", n, 34);
        chk("timeout_err", err_o, m_err);
        chk("timeout_no_valid", saw_valid, 1'b0);

        // reset in the middle of WAIT (err[1] still sticky, nonce not consumed)
        stub_mode = 0;
        go_once();
        tick(); tick(); tick(); tick();
        chk("pre_rst_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        tick();
        m_reset();
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_err", err_o, m_err);
        chk("midrst_start", init_start_o, 1'b0);
        chk("midrst_valid", out_valid_o, 1'b0);
        chk("midrst_out_state", out_state_o, '0);
        chk("midrst_init_state", init_state_o, m_init());
        rst_i = 1'b0;
        saw_start = 1'b0;
        saw_busy  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (init_start_o) saw_start = 1'b1;
            if (busy_o)       saw_busy  = 1'b1;
        end
        chk("post_rst_no_start", saw_start, 1'b0);
        chk("post_rst_idle", saw_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascon_state_loader.md
Name: ascon_state_loader

Overview:
- Upstream feeder and post-processor for the Ascon initialization permutation stage (ascon_init).
- Collects a 128-bit key and a 128-bit nonce over a 32-bit word-write interface, then builds the initial state IV||K||N.
- Launches the 12-round initialization and captures the permuted state.
- Applies the closing key XOR to x3/x4 and hands the initialized state downstream with a valid/ready handshake.

Parameters:
- IV, 64'h80400c0600000000, initialization vector loaded into x0 (Ascon-128).
- TIMEOUT_CYCLES, 32, max cycles in WAIT before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- we_i  in  1  word write strobe
- addr_i  in  3  word index: 0-3 key, 4-7 nonce
- wdata_i  in  32  write data
- go_i  in  1  request an initialization run
- clr_err_i  in  1  clear sticky errors
- busy_o  out  1  high in every FSM state except IDLE
- err_o  out  2  sticky errors: [0] go with incomplete load, [1] timeout
- init_start_o  out  1  start pulse to the init stage
- init_state_o  out  320 (state_t)  initial state to the init stage
- init_state_i  in  320 (state_t)  permuted state from the init stage
- init_update_i  in  1  init_state_i is valid this cycle
- init_finished_i  in  1  init stage completion pulse
- out_state_o  out  320 (state_t)  initialized state
- out_valid_o  out  1  out_state_o valid
- out_ready_i  in  1  downstream accepts

Behaviour:
- Clock/reset: single clock clk_i. Reset is synchronous, active high (rst_i); all registers update only on the rising edge of clk_i.
- Reset values: FSM=IDLE, key/nonce registers and load mask = 0, err_o=0, init_start_o=0, out_valid_o=0, busy_o=0; state register = 0.
- Word mapping (big-endian):
  - addr w in 0-3 writes key[127-32w -: 32].
  - addr w in 4-7 writes nonce[127-32(w-4) -: 32].
  - Each write sets bit w of an 8-bit load mask.
- Writes are accepted only in IDLE. A write while busy_o=1 is dropped silently.
- init_state_o is combinational from the registers: x0=IV, x1=key[127:64], x2=key[63:0], x3=nonce[127:64], x4=nonce[63:0]. It is stable throughout START and WAIT.
- FSM:
  - IDLE: go_i with mask==8'hFF -> START. go_i with mask!=8'hFF -> set err_o[0], stay in IDLE.
  - START: init_start_o=1 for exactly one cycle; clear timeout counter -> WAIT.
  - WAIT:
    - Each cycle with init_update_i=1, state register <= init_state_i.
    - init_finished_i=1 -> FINAL. The last update precedes finished by one cycle; if update and finished coincide, capture first, then go to FINAL.
    - Counter increments each cycle. Reaching TIMEOUT_CYCLES without finished -> set err_o[1], go to IDLE, no output.
  - FINAL: x3 ^= key[127:64], x4 ^= key[63:0]; clear nonce mask bits [7:4] (key bits kept) -> OUT.
  - OUT: out_valid_o=1, out_state_o = state register. Hold both stable until out_ready_i=1; the transfer completes on that cycle -> IDLE.
- Latency: go_i accepted to out_valid_o = 1 (START) + init latency + 1 (FINAL) cycles. With a 12-round init stage: go at cycle 0, valid at cycle 15.
- Nonce reuse guard: a second go_i without rewriting all 4 nonce words raises err_o[0].
- err_o bits are sticky. clr_err_i clears them; if a set event coincides with clr_err_i, the set wins.
- go_i while busy_o=1 is ignored, with no error.
- rst_i mid-run: immediate return to the reset values. A pending init run is abandoned; no start pulse is reissued.

Decomposition:
- Shared package holds: state_t (array of five 64-bit words), ASCON128_IV constant, key/nonce word-index constants, and the FSM enum (IDLE, START, WAIT, FINAL, OUT).
- No sub-module; a single module.

Test Plan:
- Load key=000102..0f, nonce=000102..0f, go -> init_state_o is x0=80400c0600000000, x1=0001020304050607, x2=08090a0b0c0d0e0f, x3=0001020304050607, x4=08090a0b0c0d0e0f; init_start_o high for exactly 1 cycle.
- Real init stage connected, same inputs -> out_state_o matches the golden Ascon-128 model after init plus key XOR; out_valid_o rises 15 cycles after go.
- Stub init returning all-zero state -> out_state_o x0..x2=0, x3=0001020304050607, x4=08090a0b0c0d0e0f.
- Write only 7 words, then go -> err_o=2'b01, no start pulse. Second run without new nonce writes -> err_o[0] set. clr_err_i -> err_o=0.
- Stub init that never asserts finished -> after 32 WAIT cycles err_o[1]=1, busy_o=0, out_valid_o never asserted.
- Hold out_ready_i=0 for 10 cycles -> out_valid_o and out_state_o stable; writes are dropped. Assert rst_i in WAIT -> all outputs reach reset values on the next edge.
